// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: widths, control bundle layout and the ID/EX update actions.
package riscv_pipe_pkg;

  localparam int N_DEF  = 32;
  localparam int AW_DEF = 5;
  localparam int CW_DEF = 8;

  // Control bundle layout {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  localparam logic [CW_DEF-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    UPD_CLEAR,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_LOAD
  } upd_e;

  // Flush beats stall; stall beats the load-use bubble.
  function automatic upd_e pick_update(input logic rst, input logic flush,
                                       input logic stall, input logic load_use);
    if (rst)           return UPD_CLEAR;
    else if (flush)    return UPD_BUBBLE;
    else if (stall)    return UPD_HOLD;
    else if (load_use) return UPD_BUBBLE;
    else               return UPD_LOAD;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: EX holds a load whose destination feeds the decode slot.
module load_use_detect #(
  parameter int AW = 5
) (
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rd,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  output logic          load_use_stall
);

  always_comb begin
    load_use_stall = 1'b0;
    if (!rst) begin
      load_use_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion and writeback bypass on capture and hold.
module id_ex_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [N-1:0]  id_pc,
  input  logic [N-1:0]  id_rs1_data,
  input  logic [N-1:0]  id_rs2_data,
  input  logic [N-1:0]  id_imm,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic [CW-1:0] id_ctrl,
  input  logic [3:0]    id_func,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  output logic          ex_valid,
  output logic [N-1:0]  ex_pc,
  output logic [N-1:0]  ex_rs1_data,
  output logic [N-1:0]  ex_rs2_data,
  output logic [N-1:0]  ex_imm,
  output logic [AW-1:0] ex_rs1,
  output logic [AW-1:0] ex_rs2,
  output logic [AW-1:0] ex_rd,
  output logic [CW-1:0] ex_ctrl,
  output logic [3:0]    ex_func,
  output logic          load_use_stall
);

  logic          valid_q, valid_d;
  logic [N-1:0]  pc_q, pc_d, rs1d_q, rs1d_d, rs2d_q, rs2d_d, imm_q, imm_d;
  logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [3:0]    func_q, func_d;
  upd_e          upd;
  logic          wb_live;

  load_use_detect #(.AW(AW)) u_lud (
    .rst            (rst),
    .ex_valid       (valid_q),
    .ex_mem_read    (ctrl_q[CTRL_MEM_READ]),
    .ex_rd          (rd_q),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .load_use_stall (load_use_stall)
  );

  assign upd     = pick_update(rst, flush, stall, load_use_stall);
  assign wb_live = wb_we & (wb_rd != '0);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    func_d  = func_q;
    unique case (upd)
      UPD_CLEAR, UPD_BUBBLE: begin
        valid_d = 1'b0;
        pc_d    = '0;
        rs1d_d  = '0;
        rs2d_d  = '0;
        imm_d   = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        ctrl_d  = CW'(BUBBLE_CTRL);
        func_d  = '0;
      end
      // Held operands still track writeback so they are current when the stall releases.
      UPD_HOLD: begin
        if (valid_q && wb_live && wb_rd == rs1_q) rs1d_d = wb_data;
        if (valid_q && wb_live && wb_rd == rs2_q) rs2d_d = wb_data;
      end
      UPD_LOAD: begin
        valid_d = id_valid;
        pc_d    = id_pc;
        rs1d_d  = (wb_live && wb_rd == id_rs1) ? wb_data : id_rs1_data;
        rs2d_d  = (wb_live && wb_rd == id_rs2) ? wb_data : id_rs2_data;
        imm_d   = id_imm;
        rs1_d   = id_rs1;
        rs2_d   = id_rs2;
        rd_d    = id_rd;
        ctrl_d  = id_valid ? id_ctrl : CW'(BUBBLE_CTRL);
        func_d  = id_func;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      func_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      func_q  <= func_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1d_q;
  assign ex_rs2_data = rs2d_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_func     = func_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: expected EX contents are queued when stimulus is driven and checked after the edge.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [3:0]  func;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, wb_we;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [7:0]  id_ctrl;
  logic [3:0]  id_func;
  logic        ex_valid, load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [3:0]  ex_func;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  ex_t   cur;
  ex_t   exp_q[$];
  string tag_q[$];

  id_ex_pipe_reg #(.N(32), .AW(5), .CW(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl), .id_func(id_func),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_func(ex_func), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [7:0] ctrl,
                        input logic [3:0] func);
    id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = ctrl; id_func = func;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we = we; wb_rd = rd; wb_data = data;
  endtask

  task automatic check_lus(input logic expv, input string tag);
    #1;
    checks++;
    assert (load_use_stall === expv) else begin
      failures++;
      $error("FAIL %s: load_use_stall=%b expected %b", tag, load_use_stall, expv);
    end
  endtask

  task automatic tick_and_check();
    ex_t   got, want;
    string tag;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      got  = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
              ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_func};
      assert (got === want) else begin
        failures++;
        $error("FAIL %s: ex=%h expected %h", tag, got, want);
      end
    end
  endtask

  task automatic push(input string tag);
    exp_q.push_back(cur);
    tag_q.push_back(tag);
    tick_and_check();
  endtask

  task automatic go_bubble(input string tag);
    cur = '0;
    push(tag);
  endtask

  task automatic go_load(input string tag);
    cur.valid = id_valid;
    cur.pc    = id_pc;
    cur.rs1d  = (wb_we && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    cur.rs2d  = (wb_we && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    cur.imm   = id_imm;
    cur.rs1   = id_rs1;
    cur.rs2   = id_rs2;
    cur.rd    = id_rd;
    cur.ctrl  = id_valid ? id_ctrl : 8'h00;
    cur.func  = id_func;
    push(tag);
  endtask

  task automatic go_hold(input string tag);
    if (cur.valid && wb_we && wb_rd != 0 && wb_rd == cur.rs1) cur.rs1d = wb_data;
    if (cur.valid && wb_we && wb_rd != 0 && wb_rd == cur.rs2) cur.rs2d = wb_data;
    push(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h40, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 8'hFF, 4'hF);

    // Reset for two cycles with a live decode slot
    go_bubble("reset_c1");
    check_lus(1'b0, "reset_lus");
    go_bubble("reset_c2");
    rst = 1'b0;

    // Plain load
    set_id(1'b1, 32'h100, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd5, 8'h88, 4'h2);
    check_lus(1'b0, "plain_lus");
    go_load("plain_load");

    // Load instruction into EX
    set_id(1'b1, 32'h104, 32'h33, 32'h44, 32'h8, 5'd5, 5'd1, 5'd6, 8'hD0, 4'h2);
    check_lus(1'b0, "lw_lus");
    go_load("lw_load");

    // Consumer with rs2 = 6: invalid slot masks the hazard, valid slot raises it
    set_id(1'b0, 32'h108, 32'h55, 32'h66, 32'h0, 5'd1, 5'd6, 5'd7, 8'h80, 4'h0);
    check_lus(1'b0, "lu_invalid_id");
    id_valid = 1'b1;
    check_lus(1'b1, "lu_detect");
    go_bubble("lu_bubble");
    check_lus(1'b0, "lu_cleared");
    go_load("lu_reload");

    // WB bypass on capture; rs2 evaluated independently
    set_id(1'b1, 32'h10C, 32'hAAAA, 32'hBBBB, 32'h4, 5'd3, 5'd4, 5'd8, 8'h80, 4'h8);
    set_wb(1'b1, 5'd3, 32'h5555);
    go_load("wb_byp_rs1");
    set_id(1'b1, 32'h110, 32'hAAAA, 32'hBBBB, 32'h4, 5'd0, 5'd0, 5'd8, 8'h80, 4'h1);
    set_wb(1'b1, 5'd0, 32'h5555);
    go_load("wb_x0_nobyp");
    set_id(1'b1, 32'h114, 32'hC1, 32'hC2, 32'h4, 5'd10, 5'd9, 5'd8, 8'h80, 4'h1);
    set_wb(1'b1, 5'd9, 32'h9999);
    go_load("wb_byp_rs2");

    // Held entry with rs2 = 7; writeback to r7 lands in the second stall cycle
    set_id(1'b1, 32'h200, 32'h8888, 32'h7777, 32'h10, 5'd8, 5'd7, 5'd9, 8'h88, 4'h3);
    set_wb(1'b0, 5'd0, 32'h0);
    go_load("hold_entry");
    stall = 1'b1;
    set_id(1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 8'hFF, 4'hF);
    go_hold("hold_c1");
    set_wb(1'b1, 5'd7, 32'h1234);
    go_hold("hold_c2_byp");
    set_wb(1'b0, 5'd0, 32'h0);
    go_hold("hold_c3");
    stall = 1'b0;

    // Flush and stall together with a live hazard
    set_id(1'b1, 32'h300, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd10, 8'hD0, 4'h2);
    go_load("lw_r10");
    set_id(1'b1, 32'h304, 32'h3, 32'h4, 32'h0, 5'd10, 5'd2, 5'd11, 8'h80, 4'h0);
    flush = 1'b1; stall = 1'b1;
    check_lus(1'b1, "flush_stall_lus");
    go_bubble("flush_over_stall");
    flush = 1'b0; stall = 1'b0;

    // Stall beats load-use, then bubble, then reload
    set_id(1'b1, 32'h400, 32'h3, 32'h4, 32'h0, 5'd3, 5'd4, 5'd11, 8'hD0, 4'h2);
    go_load("lw_r11");
    set_id(1'b1, 32'h404, 32'h5, 32'h6, 32'h0, 5'd1, 5'd11, 5'd12, 8'h80, 4'h0);
    stall = 1'b1;
    check_lus(1'b1, "stall_lus");
    go_hold("stall_over_lu");
    stall = 1'b0;
    check_lus(1'b1, "lu_after_stall");
    go_bubble("lu_bubble2");
    check_lus(1'b0, "lu_cleared2");
    go_load("lu_reload2");

    // Reset during stall with a hazard pending
    set_id(1'b1, 32'h500, 32'h7, 32'h8, 32'h0, 5'd1, 5'd2, 5'd12, 8'hD0, 4'h2);
    go_load("lw_r12");
    set_id(1'b1, 32'h504, 32'h9, 32'hA, 32'h0, 5'd12, 5'd2, 5'd13, 8'h80, 4'h0);
    stall = 1'b1; rst = 1'b1;
    check_lus(1'b0, "rst_masks_lus");
    go_bubble("rst_mid_stall");
    stall = 1'b0; rst = 1'b0;

    // Invalid decode slot: fields captured but control zeroed
    set_id(1'b0, 32'h600, 32'hAB, 32'hCD, 32'hEF, 5'd4, 5'd5, 5'd6, 8'hFF, 4'h7);
    go_load("invalid_load");

    // Load to x0 never raises a hazard
    set_id(1'b1, 32'h700, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd0, 8'hD0, 4'h2);
    go_load("lw_x0");
    set_id(1'b1, 32'h704, 32'h3, 32'h4, 32'h0, 5'd0, 5'd0, 5'd1, 8'h80, 4'h0);
    check_lus(1'b0, "lu_x0");
    go_load("after_lw_x0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
